// File: rtl/oled_text_scheduler.sv
// Four-way scheduler for the OLED controller's write/update ports: captures one 16-char
// row, issues 16 character writes, then one non-clearing update. Define OLED_SCHED_RR_EN for round-robin.
module oled_text_scheduler #(
  parameter int ROW_CHARS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                req,
  input  logic [4*8*ROW_CHARS-1:0]  row_text,
  output logic [3:0]                ack,
  output logic                      busy,
  output logic [1:0]                cur_row,
  output logic                      write_start,
  output logic [8:0]                write_base_addr,
  output logic [7:0]                write_ascii_data,
  input  logic                      write_ready,
  output logic                      update_start,
  output logic                      update_clear,
  input  logic                      update_ready
);

  localparam int ROW_BITS = 8 * ROW_CHARS;

  typedef enum logic [2:0] {IDLE, WR, WWAIT, UPD, UWAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          col;
  logic [ROW_BITS-1:0] text_q;
  logic [1:0]          winner;
  logic                grant, issue_wr, next_col, issue_upd, done;

  assign update_clear = 1'b0;

`ifdef OLED_SCHED_RR_EN
  logic [1:0] rr_ptr;
  logic [1:0] probe;

  // Walk from farthest to nearest so the row just after the last grant wins.
  always_comb begin
    winner = 2'd0;
    probe  = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      probe = rr_ptr + 2'(k);
      if (req[probe]) winner = probe;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= 2'd3;
    else if (grant) rr_ptr <= winner;
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) winner = 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    issue_wr  = 1'b0;
    next_col  = 1'b0;
    issue_upd = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: if (|req) begin
        grant   = 1'b1;
        state_d = WR;
      end
      WR: if (write_ready) begin
        issue_wr = 1'b1;
        state_d  = WWAIT;
      end
      WWAIT: if (write_ready) begin
        if (col == 4'(ROW_CHARS - 1)) begin
          state_d = UPD;
        end else begin
          next_col = 1'b1;
          state_d  = WR;
        end
      end
      UPD: if (update_ready) begin
        issue_upd = 1'b1;
        state_d   = UWAIT;
      end
      UWAIT: if (update_ready) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack              <= '0;
      busy             <= 1'b0;
      cur_row          <= '0;
      col              <= '0;
      write_start      <= 1'b0;
      write_base_addr  <= '0;
      write_ascii_data <= '0;
      update_start     <= 1'b0;
    end else begin
      ack          <= '0;
      write_start  <= issue_wr;
      update_start <= issue_upd;
      if (grant) begin
        ack     <= 4'b0001 << winner;
        busy    <= 1'b1;
        cur_row <= winner;
        col     <= '0;
      end
      if (issue_wr) begin
        write_base_addr  <= {cur_row, col, 3'b000};
        write_ascii_data <= text_q[{~col, 3'b000} +: 8];
      end
      if (next_col) col  <= col + 4'd1;
      if (done)     busy <= 1'b0;
    end
  end

  // NOTE: the text buffer has no reset; it is always loaded at grant before any write reads it.
  always_ff @(posedge clk) begin
    if (grant) text_q <= row_text[winner * ROW_BITS +: ROW_BITS];
  end

endmodule

// File: tb/tb_oled_text_scheduler.sv
// Directed bench for oled_text_scheduler: single row, controller stall, text change
// mid-row, contention ordering and mid-row reset, against hand-computed values.
module tb_oled_text_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [511:0] row_text;
  logic [3:0]   ack;
  logic         busy;
  logic [1:0]   cur_row;
  logic         write_start;
  logic [8:0]   write_base_addr;
  logic [7:0]   write_ascii_data;
  logic         write_ready;
  logic         update_start;
  logic         update_clear;
  logic         update_ready;

  oled_text_scheduler #(.ROW_CHARS(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .row_text         (row_text),
    .ack              (ack),
    .busy             (busy),
    .cur_row          (cur_row),
    .write_start      (write_start),
    .write_base_addr  (write_base_addr),
    .write_ascii_data (write_ascii_data),
    .write_ready      (write_ready),
    .update_start     (update_start),
    .update_clear     (update_clear),
    .update_ready     (update_ready)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records every write command and counts updates, busy cycles and strobe overlaps.
  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  wq[$];
  int   upd_cnt  = 0;
  int   busy_cnt = 0;
  int   viol     = 0;
  logic prev_ws  = 1'b0;
  logic prev_us  = 1'b0;

  always @(negedge clk) begin
    if (write_start)  wq.push_back({write_base_addr, write_ascii_data});
    if (update_start) upd_cnt++;
    if (busy)         busy_cnt++;
    if ((write_start && update_start) || (write_start && prev_ws) || (update_start && prev_us))
      viol++;
    prev_ws = write_start;
    prev_us = update_start;
  end

  // Advance to just after the falling edge, once the monitor has run.
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    wq.delete();
    upd_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_ack;
    int b = 0;
    while (ack == 4'b0000 && b < 100) begin
      tick();
      b++;
    end
    check("ack_seen", {31'd0, |ack}, 32'd1);
  endtask

  task automatic wait_idle;
    int b = 0;
    while (busy && b < 400) begin
      tick();
      b++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_row(input logic [1:0] row, input logic [127:0] txt);
    wr_t         w;
    logic [127:0] t;
    int          n;
    n = wq.size();
    check($sformatf("row%0d_nwrites", row), n, 16);
    t = txt;
    for (int i = 0; i < 16 && wq.size() > 0; i++) begin
      w = wq.pop_front();
      check($sformatf("row%0d_addr_c%0d", row, i), {23'd0, w.addr}, 32'(row) * 128 + 32'(i) * 8);
      check($sformatf("row%0d_data_c%0d", row, i), {24'd0, w.data}, {24'd0, t[127 - 8*i -: 8]});
    end
    check($sformatf("row%0d_nupdates", row), upd_cnt, 1);
    clear_mon();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},     {28'd0, ack}, 32'd0);
    check({tag, "_busy"},    {31'd0, busy}, 32'd0);
    check({tag, "_cur_row"}, {30'd0, cur_row}, 32'd0);
    check({tag, "_wstart"},  {31'd0, write_start}, 32'd0);
    check({tag, "_waddr"},   {23'd0, write_base_addr}, 32'd0);
    check({tag, "_wdata"},   {24'd0, write_ascii_data}, 32'd0);
    check({tag, "_ustart"},  {31'd0, update_start}, 32'd0);
    check({tag, "_uclear"},  {31'd0, update_clear}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] txt_a, txt_b;
    int           b, gap;

    rst          = 1'b1;
    req          = 4'b0000;
    row_text     = '0;
    write_ready  = 1'b1;
    update_ready = 1'b1;
    do_reset();
    check_outputs_zero("reset");

    // Single request, always-ready controller: row 1 "HELLO WORLD     "
    txt_a = "HELLO WORLD     ";
    row_text[128 +: 128] = txt_a;
    clear_mon();
    req = 4'b0010;
    tick();
    check("single_ack",     {28'd0, ack}, 32'h2);
    check("single_busy",    {31'd0, busy}, 32'd1);
    check("single_cur_row", {30'd0, cur_row}, 32'd1);
    check("single_wstart0", {31'd0, write_start}, 32'd0);
    req = 4'b0000;
    tick();
    check("single_ack_pulse", {28'd0, ack}, 32'd0);
    check("single_wstart1",   {31'd0, write_start}, 32'd1);
    check("single_addr0",     {23'd0, write_base_addr}, 32'h080);
    check("single_data0",     {24'd0, write_ascii_data}, 32'h48);
    wait_idle();
    // Grant cycle plus 34 busy cycles makes the 35-cycle minimum row.
    check("single_busy_cycles", busy_cnt, 34);
    check("single_uclear", {31'd0, update_clear}, 32'd0);
    check_row(2'd1, txt_a);

    // Controller stall: ready low for 10 cycles while col 7 is pending
    txt_a = "0123456789ABCDEF";
    row_text[0 +: 128] = txt_a;
    clear_mon();
    req = 4'b0001;
    tick();
    check("stall_ack", {28'd0, ack}, 32'h1);
    req = 4'b0000;
    b = 0;
    while (wq.size() < 7 && b < 100) begin
      tick();
      b++;
    end
    check("stall_reached_col7", wq.size(), 7);
    write_ready = 1'b0;
    repeat (10) tick();
    check("stall_no_write", wq.size(), 7);
    write_ready = 1'b1;
    wait_idle();
    check("stall_busy_cycles", busy_cnt, 44);
    check_row(2'd0, txt_a);

    // Text altered after capture must not reach the writes
    txt_a = "ABCDEFGHIJKLMNOP";
    txt_b = "zzzzzzzzzzzzzzzz";
    row_text[256 +: 128] = txt_a;
    clear_mon();
    req = 4'b0100;
    tick();
    check("capture_ack", {28'd0, ack}, 32'h4);
    req = 4'b0000;
    row_text[256 +: 128] = txt_b;
    wait_idle();
    check_row(2'd2, txt_a);

    // Contention with all four rows requesting
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack();
`ifdef OLED_SCHED_RR_EN
      check($sformatf("contend_ack_g%0d", g), {28'd0, ack}, 32'd1 << (g % 4));
      check($sformatf("contend_row_g%0d", g), {30'd0, cur_row}, 32'(g % 4));
`else
      check($sformatf("contend_ack_g%0d", g), {28'd0, ack}, 32'h1);
      check($sformatf("contend_row_g%0d", g), {30'd0, cur_row}, 32'd0);
`endif
      wait_idle();
      if (g < 4) begin
        gap = 0;
        do begin
          tick();
          gap++;
        end while (ack == 4'b0000 && gap < 20);
        check($sformatf("contend_gap_g%0d", g), gap, 1);
      end
    end
    req = 4'b0000;
    tick();
    clear_mon();

    // Reset in the middle of row 3 (col 9), request still asserted
    txt_a = "RESET TEST ROW 3";
    row_text[384 +: 128] = txt_a;
    clear_mon();
    req = 4'b1000;
    wait_ack();
    b = 0;
    while (wq.size() < 10 && b < 100) begin
      tick();
      b++;
    end
    check("midrst_reached_col9", wq.size(), 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_zero("midrst");
    clear_mon();
    wait_ack();
    check("midrst_regrant_ack", {28'd0, ack}, 32'h8);
    tick();
    check("midrst_first_wstart", {31'd0, write_start}, 32'd1);
    check("midrst_first_addr",   {23'd0, write_base_addr}, 32'h180);
    req = 4'b0000;
    wait_idle();
    check_row(2'd3, txt_a);

    check("strobe_protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
